// File: rtl/tcu_multi_channel.sv
// tcu_multi_channel
//   Multi-zone temperature control unit. Polls NUM_CH sensors round-robin
//   through an external I2C read engine (req/ack, then done/err pulse),
//   applies a dead-band proportional law per channel and drives per-channel
//   heater enable, direction and DAC code. A bus error or a timeout faults
//   the channel and forces its drive off until its next good read.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   polling enable
//   setpoint                 packed per-channel setpoints (CU_WIDTH each)
//   i2c_req/ack              request handshake; req held until ack
//   i2c_dev_addr/reg_addr    sensor address (ADDR_BASE+ch), register address
//   i2c_done/err/rdata       completion pulses and read data
//   on_off, increase_decrease_temp, Control_unit_out  per-channel drive
//   data_valid, ch_idx       good-update pulse and serviced channel
//   fault                    per-channel fault flags
module tcu_multi_channel #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned CU_WIDTH         = 16,
  parameter int unsigned DAC_WIDTH        = 8,
  parameter int unsigned NOISE_THRESHOLD  = 1,
  parameter logic [6:0]  ADDR_BASE        = 7'h48,
  parameter logic [7:0]  TARGET_READ_ADDR = 8'h00,
  parameter int unsigned POLL_INTERVAL    = 1000,
  parameter int unsigned TIMEOUT          = 100000,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH*CU_WIDTH-1:0]    setpoint,
  output logic                          i2c_req,
  output logic [6:0]                    i2c_dev_addr,
  output logic [7:0]                    i2c_reg_addr,
  input  logic                          i2c_ack,
  input  logic                          i2c_done,
  input  logic                          i2c_err,
  input  logic [CU_WIDTH-1:0]           i2c_rdata,
  output logic [NUM_CH-1:0]             on_off,
  output logic [NUM_CH-1:0]             increase_decrease_temp,
  output logic [NUM_CH*DAC_WIDTH-1:0]   Control_unit_out,
  output logic                          data_valid,
  output logic [CH_W-1:0]               ch_idx,
  output logic [NUM_CH-1:0]             fault
);

  localparam int unsigned IVL_W = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ERR_W = CU_WIDTH + 1;

  localparam logic [IVL_W-1:0]     IVL_LAST = IVL_W'(POLL_INTERVAL - 1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [ERR_W-1:0]     THR      = ERR_W'(NOISE_THRESHOLD);
  localparam logic [DAC_WIDTH-1:0] DAC_MAX  = {DAC_WIDTH{1'b1}};
  localparam logic [ERR_W-1:0]     DAC_MAX_EXT = ERR_W'(DAC_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INTERVAL,
    S_REQ,
    S_WAIT_DONE,
    S_UPDATE
  } state_e;

  state_e               state_q;
  logic [CH_W-1:0]      ch_idx_q;
  logic [IVL_W-1:0]     ivl_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic                 req_q;
  logic [6:0]           addr_q;
  logic [NUM_CH-1:0]    on_off_q;
  logic [NUM_CH-1:0]    dir_q;
  logic [NUM_CH-1:0]    fault_q;
  logic                 valid_q;
  logic [DAC_WIDTH-1:0] dac_q [NUM_CH];

  logic [CU_WIDTH-1:0]  sp_arr [NUM_CH];

  // Control-law next values for the channel currently being serviced
  logic [CU_WIDTH-1:0]     sp_sel;
  logic signed [ERR_W-1:0] err_s;
  logic [ERR_W-1:0]        abs_err;
  logic                    on_d;
  logic                    dir_d;
  logic [DAC_WIDTH-1:0]    dac_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sp_arr[g] = setpoint[g*CU_WIDTH +: CU_WIDTH];
    assign Control_unit_out[g*DAC_WIDTH +: DAC_WIDTH] = dac_q[g];
  end

  assign i2c_req                = req_q;
  assign i2c_dev_addr           = addr_q;
  assign i2c_reg_addr           = TARGET_READ_ADDR;
  assign on_off                 = on_off_q;
  assign increase_decrease_temp = dir_q;
  assign data_valid             = valid_q;
  assign ch_idx                 = ch_idx_q;
  assign fault                  = fault_q;

  // Dead-band control law on the incoming reading for the serviced channel
  always_comb begin
    sp_sel  = sp_arr[ch_idx_q];
    err_s   = $signed({1'b0, i2c_rdata}) - $signed({1'b0, sp_sel});
    abs_err = '0;
    on_d    = 1'b0;
    dir_d   = dir_q[ch_idx_q];
    dac_d   = '0;
    if (err_s[CU_WIDTH]) begin
      abs_err = -err_s;
    end else begin
      abs_err = err_s;
    end
    if (abs_err <= THR) begin
      // Inside the dead-band: drive off, direction keeps its last value.
      on_d  = 1'b0;
      dir_d = dir_q[ch_idx_q];
      dac_d = '0;
    end else begin
      on_d  = 1'b1;
      dir_d = err_s[CU_WIDTH];
      if (abs_err > DAC_MAX_EXT) begin
        dac_d = DAC_MAX;
      end else begin
        dac_d = abs_err[DAC_WIDTH-1:0];
      end
    end
  end

  // Polling FSM with registered handshake and per-channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_idx_q  <= '0;
      ivl_cnt_q <= '0;
      to_cnt_q  <= '0;
      req_q     <= 1'b0;
      addr_q    <= 7'h00;
      on_off_q  <= '0;
      dir_q     <= '0;
      fault_q   <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        dac_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q   <= S_WAIT_INTERVAL;
            ivl_cnt_q <= '0;
          end
        end
        S_WAIT_INTERVAL: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (ivl_cnt_q == IVL_LAST) begin
            state_q  <= S_REQ;
            ch_idx_q <= '0;
            req_q    <= 1'b1;
            addr_q   <= ADDR_BASE;
          end else begin
            ivl_cnt_q <= ivl_cnt_q + IVL_W'(1);
          end
        end
        S_REQ: begin
          if (i2c_ack) begin
            req_q    <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          // Error takes priority over a simultaneous done.
          if (i2c_err || (to_cnt_q == TO_LAST)) begin
            fault_q[ch_idx_q]  <= 1'b1;
            on_off_q[ch_idx_q] <= 1'b0;
            dac_q[ch_idx_q]    <= '0;
            state_q            <= S_UPDATE;
          end else if (i2c_done) begin
            fault_q[ch_idx_q]  <= 1'b0;
            on_off_q[ch_idx_q] <= on_d;
            dir_q[ch_idx_q]    <= dir_d;
            dac_q[ch_idx_q]    <= dac_d;
            valid_q            <= 1'b1;
            state_q            <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // A dropped enable lets the finished channel stand, then stops.
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (ch_idx_q == LAST_CH) begin
            state_q   <= S_WAIT_INTERVAL;
            ivl_cnt_q <= '0;
          end else begin
            ch_idx_q <= ch_idx_q + CH_W'(1);
            req_q    <= 1'b1;
            addr_q   <= ADDR_BASE + 7'(ch_idx_q) + 7'd1;
            state_q  <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcu_multi_channel.sv
module tb_tcu_multi_channel;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] setpoint;
  logic        i2c_req;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic        i2c_ack;
  logic        i2c_done;
  logic        i2c_err;
  logic [15:0] i2c_rdata;
  logic [1:0]  on_off;
  logic [1:0]  increase_decrease_temp;
  logic [15:0] Control_unit_out;
  logic        data_valid;
  logic [0:0]  ch_idx;
  logic [1:0]  fault;

  int n_chk  = 0;
  int n_pass = 0;
  int req_hi;

  tcu_multi_channel #(
    .NUM_CH(2), .CU_WIDTH(16), .DAC_WIDTH(8), .NOISE_THRESHOLD(1),
    .ADDR_BASE(7'h48), .TARGET_READ_ADDR(8'h00),
    .POLL_INTERVAL(10), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .setpoint(setpoint),
    .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_ack(i2c_ack), .i2c_done(i2c_done), .i2c_err(i2c_err), .i2c_rdata(i2c_rdata),
    .on_off(on_off), .increase_decrease_temp(increase_decrease_temp),
    .Control_unit_out(Control_unit_out), .data_valid(data_valid),
    .ch_idx(ch_idx), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; setpoint = {16'd200, 16'd100};
    i2c_ack = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0; i2c_rdata = 16'd0;

    // 1. reset, then idle with enable low
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req", 32'(i2c_req), 32'd0);
    chk("rst_addr", 32'(i2c_dev_addr), 32'd0);
    chk("rst_regaddr", 32'(i2c_reg_addr), 32'd0);
    chk("rst_onoff", 32'(on_off), 32'd0);
    chk("rst_dir", 32'(increase_decrease_temp), 32'd0);
    chk("rst_dac", 32'(Control_unit_out), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_ch", 32'(ch_idx), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    req_hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i2c_req) req_hi++;
    end
    chk("idle_no_req", 32'(req_hi), 32'd0);

    // 2. enable: request 11 cycles later, ack after 3 cycles, read 90 on ch0
    enable = 1'b1;
    repeat (10) step();
    chk("req_early", 32'(i2c_req), 32'd0);
    step();
    chk("req_rise", 32'(i2c_req), 32'd1);
    chk("addr_ch0", 32'(i2c_dev_addr), 32'h48);
    step(); step();
    chk("req_held", 32'(i2c_req), 32'd1);
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0;
    chk("req_drop", 32'(i2c_req), 32'd0);
    step();
    i2c_done = 1'b1; i2c_rdata = 16'd90;
    step();
    i2c_done = 1'b0;
    chk("u90_onoff", 32'(on_off), 32'd1);
    chk("u90_dir", 32'(increase_decrease_temp), 32'd1);
    chk("u90_dac", 32'(Control_unit_out), 32'h000a);
    chk("u90_dv", 32'(data_valid), 32'd1);
    chk("u90_ch", 32'(ch_idx), 32'd0);
    step();
    chk("req_ch1", 32'(i2c_req), 32'd1);
    chk("addr_ch1", 32'(i2c_dev_addr), 32'h49);
    chk("dv_pulse", 32'(data_valid), 32'd0);

    // 4. ch1 reads 600: error +400 saturates the DAC
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_rdata = 16'd600;
    step();
    i2c_done = 1'b0;
    chk("u600_onoff", 32'(on_off), 32'd3);
    chk("u600_dir", 32'(increase_decrease_temp), 32'd1);
    chk("u600_dac", 32'(Control_unit_out), 32'hff0a);
    chk("u600_dv", 32'(data_valid), 32'd1);
    chk("u600_ch", 32'(ch_idx), 32'd1);
    step();
    repeat (9) step();
    chk("ivl_early", 32'(i2c_req), 32'd0);
    step();
    chk("ivl_req", 32'(i2c_req), 32'd1);
    chk("ivl_addr", 32'(i2c_dev_addr), 32'h48);

    // 3. ch0 reads 101: inside dead-band, direction holds
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_rdata = 16'd101;
    step();
    i2c_done = 1'b0;
    chk("db_onoff", 32'(on_off), 32'd2);
    chk("db_dir", 32'(increase_decrease_temp), 32'd1);
    chk("db_dac", 32'(Control_unit_out), 32'hff00);
    chk("db_dv", 32'(data_valid), 32'd1);

    // 5. ch1 err with done: fault wins, then good read clears it
    step();
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_err = 1'b1; i2c_rdata = 16'd123;
    step();
    i2c_done = 1'b0; i2c_err = 1'b0;
    chk("err_fault", 32'(fault), 32'd2);
    chk("err_onoff", 32'(on_off), 32'd0);
    chk("err_dac", 32'(Control_unit_out), 32'h0000);
    chk("err_dv", 32'(data_valid), 32'd0);
    chk("err_dir", 32'(increase_decrease_temp), 32'd1);
    step();
    repeat (10) step();
    chk("sw2_req", 32'(i2c_req), 32'd1);
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_rdata = 16'd100;
    step();
    i2c_done = 1'b0;
    chk("zero_onoff", 32'(on_off), 32'd0);
    step();
    chk("sw2_addr1", 32'(i2c_dev_addr), 32'h49);
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_rdata = 16'd210;
    step();
    i2c_done = 1'b0;
    chk("rec_fault", 32'(fault), 32'd0);
    chk("rec_onoff", 32'(on_off), 32'd2);
    chk("rec_dir", 32'(increase_decrease_temp), 32'd1);
    chk("rec_dac", 32'(Control_unit_out), 32'h0a00);
    chk("rec_dv", 32'(data_valid), 32'd1);

    // 6a. ch0 timeout after 50 cycles in WAIT_DONE
    step();
    repeat (10) step();
    chk("sw3_req", 32'(i2c_req), 32'd1);
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0;
    repeat (49) step();
    chk("to_early", 32'(fault), 32'd0);
    step();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_dv", 32'(data_valid), 32'd0);
    chk("to_onoff", 32'(on_off), 32'd2);
    step();
    chk("to_next_req", 32'(i2c_req), 32'd1);
    chk("to_next_addr", 32'(i2c_dev_addr), 32'h49);
    chk("to_next_ch", 32'(ch_idx), 32'd1);

    // 6b. reset during WAIT_DONE, late done ignored
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", 32'(i2c_req), 32'd0);
    chk("mrst_fault", 32'(fault), 32'd0);
    chk("mrst_onoff", 32'(on_off), 32'd0);
    chk("mrst_ch", 32'(ch_idx), 32'd0);
    i2c_done = 1'b1; i2c_rdata = 16'd90;
    step();
    i2c_done = 1'b0;
    chk("late_dv", 32'(data_valid), 32'd0);
    chk("late_dac", 32'(Control_unit_out), 32'd0);
    repeat (9) step();
    chk("mrst_ivl_early", 32'(i2c_req), 32'd0);
    step();
    chk("mrst_ivl_req", 32'(i2c_req), 32'd1);

    // enable dropped mid-transaction: ch0 completes, then idle
    enable = 1'b0;
    i2c_ack = 1'b1;
    step();
    i2c_ack = 1'b0; i2c_done = 1'b1; i2c_rdata = 16'd90;
    step();
    i2c_done = 1'b0;
    chk("dis_dv", 32'(data_valid), 32'd1);
    chk("dis_dac", 32'(Control_unit_out), 32'h000a);
    req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i2c_req) req_hi++;
    end
    chk("dis_no_req", 32'(req_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
